// File: rtl/ram_cmd_master.sv
// Host-request to RAM command sequencer: turns one read/write request into an
// address/data command pair on cmd_out and returns a single-cycle response.
module ram_cmd_master #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [9:0] cmd_out,
  output logic       cmd_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic [2:0] dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so busy-time requests simply wait (no queue).
  // rsp_valid is a one-cycle pulse with no back-pressure.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next, cnt_inc;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic       cap_load;

  logic       cmd_valid_d;
  logic [9:0] cmd_out_d;
  logic       rsp_valid_d;
  logic [7:0] rsp_rdata_d;
  logic       rsp_err_d;

  assign cnt_inc   = cnt + 8'd1;
  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are computed for the state being entered and registered, so every
  // output changes only on a clock edge and reflects the current state.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    cap_load    = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_out_d   = 10'd0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 8'd0;
    rsp_err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next  = ADDR;
          cap_load    = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_out_d   = {(req_wr ? OP_WR_ADDR : OP_RD_ADDR), req_addr};
        end
      end
      ADDR: begin
        state_next  = DATA;
        cmd_valid_d = 1'b1;
        cmd_out_d   = wr_q ? {OP_WR_DATA, wdata_q} : {OP_RD_DATA, 8'h00};
      end
      DATA: begin
        if (wr_q) begin
          state_next  = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_next = WAIT;
          cnt_next   = 8'd0;
        end
      end
      WAIT: begin
        if (ram_tx_valid) begin
          state_next  = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ram_dout;
        end else begin
          cnt_next = cnt_inc;
          // Stopping on the compare means the counter never wraps or saturates.
          if (cnt_inc == TIMEOUT_C) begin
            state_next  = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      wdata_q   <= 8'd0;
      cmd_valid <= 1'b0;
      cmd_out   <= 10'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (cap_load) begin
        wr_q    <= req_wr;
        wdata_q <= req_wdata;
      end
      cmd_valid <= cmd_valid_d;
      cmd_out   <= cmd_out_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed/table-driven bench for ram_cmd_master with a small command-decoding
// RAM model that can answer normally, never answer, or hold tx_valid stuck high.
module tb_ram_cmd_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_wr;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [9:0] cmd_out;
  logic       cmd_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic [2:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int ram_mode = 0;  // 0 normal, 1 mute, 2 tx_valid stuck high with 0xEE
  logic [7:0] exp_q[$];

  ram_cmd_master #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cmd_out(cmd_out), .cmd_valid(cmd_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] ram_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_tx_valid <= 1'b0;
      ram_dout     <= 8'h00;
      ram_addr     <= 8'h00;
    end else begin
      ram_tx_valid <= (ram_mode == 2);
      ram_dout     <= (ram_mode == 2) ? 8'hEE : 8'h00;
      if (cmd_valid) begin
        case (cmd_out[9:8])
          2'b00, 2'b10: ram_addr <= cmd_out[7:0];
          2'b01:        mem[ram_addr] <= cmd_out[7:0];
          default: begin
            if (ram_mode == 0) begin
              ram_tx_valid <= 1'b1;
              ram_dout     <= mem[ram_addr];
            end
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request, wait for acceptance, then watch until the response.
  task automatic do_txn(input string name, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [9:0] c0, input logic [9:0] c1,
                        input int lat, input logic [7:0] rd, input logic err, output int waits);
    logic [9:0] cmds[2];
    int ccyc[2];
    int ncmd = 0;
    int got_lat = -1;
    logic [7:0] g_rd = 8'h00;
    logic g_err = 1'b0;
    int busy_bad = 0;
    int inv_bad = 0;
    logic [7:0] e;
    cmds[0] = 10'h0; cmds[1] = 10'h0; ccyc[0] = 0; ccyc[1] = 0;
    exp_q.push_back(rd);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    waits = 0;
    while (waits <= 50) begin
      @(negedge clk);
      waits++;
      if (req_ready) break;
    end
    check({name, "_accept"}, (waits <= 50) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (req_ready) busy_bad++;
      if (!cmd_valid && cmd_out != 10'h0) inv_bad++;
      if (!rsp_valid && (rsp_rdata != 8'h0 || rsp_err)) inv_bad++;
      if (cmd_valid) begin
        if (ncmd < 2) begin
          cmds[ncmd] = cmd_out;
          ccyc[ncmd] = k;
        end
        ncmd++;
      end
      if (rsp_valid) begin
        got_lat = k; g_rd = rsp_rdata; g_err = rsp_err;
        break;
      end
    end
    e = exp_q.pop_front();
    check({name, "_ncmd"}, ncmd, 2);
    check({name, "_cmd0"}, 32'(cmds[0]), 32'(c0));
    check({name, "_cmd1"}, 32'(cmds[1]), 32'(c1));
    check({name, "_cmd_cyc"}, ccyc[0] * 16 + ccyc[1], 18);
    check({name, "_latency"}, got_lat, lat);
    check({name, "_rdata"}, 32'(g_rd), 32'(e));
    check({name, "_err"}, 32'(g_err), 32'(err));
    check({name, "_busy_ready"}, busy_bad, 0);
    check({name, "_idle_zero"}, inv_bad, 0);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         mode;
    logic [9:0] c0;
    logic [9:0] c1;
    int         lat;
    logic [7:0] rd;
    logic       err;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] shadow[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    int bad;
    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 0, 10'h03C, 10'h1A5, 3, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 8'h00, 0, 10'h23C, 10'h300, 4, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 0, 10'h000, 10'h1FF, 3, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 8'h01, 0, 10'h0FF, 10'h101, 3, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 0, 10'h200, 10'h300, 4, 8'hFF, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 8'h5A, 0, 10'h2FF, 10'h300, 4, 8'h01, 1'b0};
    vecs[6] = '{1'b0, 8'h3C, 8'h00, 1, 10'h23C, 10'h300, 18, 8'h00, 1'b1};
    vecs[7] = '{1'b0, 8'h10, 8'h00, 2, 10'h210, 10'h300, 4, 8'hEE, 1'b0};
    vecs[8] = '{1'b1, 8'h10, 8'h5A, 2, 10'h010, 10'h15A, 3, 8'h00, 1'b0};
    vecs[9] = '{1'b0, 8'h10, 8'h00, 0, 10'h210, 10'h300, 4, 8'h5A, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_out", 32'(cmd_out), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data_err", 32'({rsp_rdata, rsp_err}), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 1);

    // Table vectors run back to back: each one must be taken in the first IDLE cycle.
    for (int i = 0; i < 10; i++) begin
      ram_mode = vecs[i].mode;
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].c0, vecs[i].c1, vecs[i].lat, vecs[i].rd, vecs[i].err, w);
      if (i > 0) check($sformatf("vec%0d_b2b_wait", i), w, 1);
    end
    ram_mode = 0;

    // Reset while a read is in its DATA cycle.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h3C; req_wdata = 8'h00;
    w = 0;
    while (w <= 50) begin
      @(negedge clk);
      w++;
      if (req_ready) break;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 8'h00;
    @(negedge clk);
    check("abort_addr_cmd", 32'(cmd_out), 32'h23C);
    @(negedge clk);
    check("abort_data_valid", 32'(cmd_valid), 1);
    rst_n = 1'b0;
    #1;
    check("abort_cmd_valid_drop", 32'(cmd_valid), 0);
    check("abort_cmd_out_zero", 32'(cmd_out), 0);
    check("abort_state_idle", 32'(dbg_state), 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cmd_valid || rsp_valid) bad++;
    end
    rst_n = 1'b1;
    check("abort_ready_after", 32'(req_ready), 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cmd_valid || rsp_valid) bad++;
    end
    check("abort_no_pulses", bad, 0);
    do_txn("post_rst_wr", 1'b1, 8'h01, 8'h77, 10'h001, 10'h177, 3, 8'h00, 1'b0, w);
    do_txn("post_rst_rd", 1'b0, 8'h01, 8'h00, 10'h201, 10'h300, 4, 8'h77, 1'b0, w);

    // Seed a small address window, then a random read/write mix over it.
    for (int i = 0; i < 8; i++) begin
      shadow[i] = 8'(i * 17 + 3);
      do_txn($sformatf("seed%0d", i), 1'b1, 8'h40 + 8'(i), shadow[i],
             {2'b00, 8'h40 + 8'(i)}, {2'b01, shadow[i]}, 3, 8'h00, 1'b0, w);
    end
    for (int i = 0; i < 24; i++) begin
      logic       rw;
      logic [2:0] a;
      logic [7:0] d;
      rw = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = 8'($urandom_range(0, 255));
      if (rw) begin
        shadow[a] = d;
        do_txn($sformatf("rnd%0d_wr", i), 1'b1, {5'b01000, a}, d,
               {2'b00, 5'b01000, a}, {2'b01, d}, 3, 8'h00, 1'b0, w);
      end else begin
        do_txn($sformatf("rnd%0d_rd", i), 1'b0, {5'b01000, a}, d,
               {2'b10, 5'b01000, a}, 10'h300, 4, shadow[a], 1'b0, w);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
